bitserial_lane_feeder: RTL and testbench
========================================

# bitserial_lane_feeder

Bit-serial operand feeder placed directly upstream of the 32-lane serial dot-product accumulator. It holds a 32-entry bank of 4-bit weights and accepts whole vectors of 32 4-bit activations over a valid/ready handshake. Each accepted vector is serialised MSB-first into 4 consecutive beats; on each beat, lane k carries its weight when bit b of activation k is 1, else 0. The downstream accumulator forms the 13-bit dot product by shift-and-add over those beats.

## Interface
- LANES, 32, number of lanes
- WW, 4, weight width and output lane width
- AW, 4, activation width and beats per vector
- GAP_CYCLES, 1, idle cycles forced between the last beat of one vector and the first beat of the next (0 = back-to-back)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- w_load  in  1  write strobe for the shadow weight bank
- w_addr  in  5  lane index 0..31
- w_data  in  WW  weight value
- in_valid  in  1  activation vector valid
- in_ready  out  1  feeder can accept a vector
- act_in  in  LANES*AW  activation vector; lane k is in [4k+3:4k]
- out_valid  out  1  beat valid
- out_first  out  1  first beat of a vector (bit 3)
- out_last  out  1  last beat of a vector (bit 0)
- bit_idx  out  2  activation bit carried by this beat
- lane_out  out  LANES*WW  lane k is in [4k+3:4k]; lane 0 feeds Input_1

## Operation
**Weight banks**
- A shadow bank is written one entry per cycle when w_load=1.
- At vector start, the active bank is copied from the shadow bank. A write in the same cycle as a start is not included in that copy.
- A vector in flight always uses the weights captured at its start.

**Buffering**
- The shift register holds the vector in flight.
- One pending register holds the next vector.
- in_ready = !pend_valid.
- An accept (in_valid && in_ready) goes straight into the shift register when the engine is free this cycle. Otherwise it goes into pending.

**FSM**
- IDLE -> SHIFT on a direct accept, or when pending is valid.
- SHIFT runs 4 beats with bit_idx = 3, 2, 1, 0.
- After the bit-0 beat:
  - go to GAP if GAP_CYCLES > 0;
  - otherwise go to SHIFT if a vector is available, else IDLE.
- GAP counts GAP_CYCLES cycles, then goes to SHIFT if a vector is available, else IDLE.
- "Engine free this cycle" means: IDLE, the final GAP cycle, or the bit-0 beat when GAP_CYCLES = 0.
- When the engine is free and pending is valid, pending is moved to the shift register. pend_valid clears and in_ready rises on the next cycle.

**Beat contents and arithmetic**
- Each beat: lane_out[k] = act[k][bit_idx] ? w_active[k] : 0.
- Beats carry no arithmetic. The downstream sum is Σ_b 2^b·Σ_k lane_out[k]; the maximum is 32·15·15 = 7200, which fits in 13 bits.

**Reset (asynchronous, any time including mid-burst)**
- out_valid, out_first, out_last = 0; bit_idx = 0; lane_out = 0.
- in_ready = 1; pend_valid = 0.
- Both weight banks = 0; FSM = IDLE.
- The vector in flight and any pending vector are discarded.

## Timing
- All outputs are registered.
- An accept at edge T into a free engine gives beats on cycles T+1..T+4.
- out_first is asserted on T+1 and out_last on T+4.
- The next burst begins GAP_CYCLES cycles after the out_last cycle, or immediately when GAP_CYCLES = 0.
- Beats of a vector are never interrupted and there is no downstream backpressure.
- out_valid is 0 in IDLE and GAP, and lane_out = 0 whenever out_valid = 0.
- in_ready falls the cycle after a vector enters pending.

## Test plan
- **Reset mid-burst:** assert rst on beat 2 with a vector pending -> out_valid=0 and lane_out=0 immediately; in_ready=1; no further beats; after reset a weight read-back burst shows all lanes 0.
- **Full scale:** all weights 15, all activations 15 -> 4 beats, every lane 15, out_first on beat 1, out_last on beat 4, shift-add sum 7200.
- **Bit pattern:** w[k] = k mod 16, act[k] = 4'b1010 -> lanes read w[k], 0, w[k], 0 with bit_idx 3, 2, 1, 0.
- **Streaming:** in_valid held high for three vectors A, B, C with GAP_CYCLES=1 ->
  - A's beats start the next cycle;
  - B enters pending and in_ready drops;
  - B's first beat comes exactly 2 cycles after A's out_last;
  - C is accepted only when B leaves pending.
  - Repeat with GAP_CYCLES=0 -> 12 contiguous out_valid cycles.
- **Weight isolation:** w[0]=3, start A with act[0]=15, write w[0]=7 on A's beat 2 -> all 4 of A's beats show lane 0 = 3; the next vector shows 7.
- **Zero activations:** all activations 0 -> 4 valid beats with lane_out = 0 and downstream sum 0.

Source files
------------

// File: rtl/bitserial_lane_feeder.sv
// Bit-serial operand feeder: double-banked weights, a one-deep vector buffer and
// MSB-first serialisation of each activation vector into gated weight beats.
module bitserial_lane_feeder #(
  parameter int LANES      = 32,
  parameter int WW         = 4,
  parameter int AW         = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_load,
  input  logic [$clog2(LANES)-1:0] w_addr,
  input  logic [WW-1:0]            w_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*AW-1:0]      act_in,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic [$clog2(AW)-1:0]    bit_idx,
  output logic [LANES*WW-1:0]      lane_out
);
  localparam int BW = $clog2(AW);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BW-1:0] BIT_MSB  = BW'(AW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  typedef logic [LANES-1:0][WW-1:0] bank_t;
  typedef logic [LANES-1:0][AW-1:0] vec_t;

  state_t        r_state, w_state_next;
  bank_t         r_w_shadow, r_w_active;
  vec_t          r_act, r_pend_act;
  logic          r_pend_valid;
  logic [BW-1:0] r_bit, w_bit_next;
  logic [GW-1:0] r_gap_cnt, w_gap_cnt_next;
  logic          r_out_valid, r_out_first, r_out_last;
  logic [BW-1:0] r_bit_idx;
  bank_t         r_lane_out;

  vec_t          w_act_in, w_start_act, w_beat_act;
  bank_t         w_beat_w, w_lane_next;
  logic          w_accept, w_free, w_start;
  logic          w_beat_valid, w_beat_first, w_beat_last;
  logic [BW-1:0] w_beat_bit;

  assign w_act_in    = act_in;
  assign in_ready    = !r_pend_valid;
  assign w_accept    = in_valid && in_ready;
  assign w_start_act = r_pend_valid ? r_pend_act : w_act_in;
  assign w_start     = w_free && (r_pend_valid || w_accept);

  // The engine may take a new vector on the cycle that ends its current duty.
  always_comb begin
    w_free = 1'b0;
    case (r_state)
      S_IDLE:  w_free = 1'b1;
      S_GAP:   w_free = (r_gap_cnt == GAP_LAST);
      S_SHIFT: w_free = (GAP_CYCLES == 0) && (r_bit == '0);
      default: w_free = 1'b0;
    endcase
  end

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    w_state_next   = r_state;
    w_bit_next     = r_bit;
    w_gap_cnt_next = r_gap_cnt;
    if (w_start) begin
      w_state_next = S_SHIFT;
      w_bit_next   = BIT_MSB;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_bit != '0) begin
            w_bit_next = r_bit - BW'(1);
          end else if (GAP_CYCLES > 0) begin
            w_state_next   = S_GAP;
            w_gap_cnt_next = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) w_state_next = S_IDLE;
          else                       w_gap_cnt_next = r_gap_cnt + GW'(1);
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // A starting vector gates the shadow bank directly: that is the copy the active bank takes.
  always_comb begin
    w_beat_valid = 1'b0;
    w_beat_first = 1'b0;
    w_beat_bit   = '0;
    w_beat_act   = r_act;
    w_beat_w     = r_w_active;
    w_lane_next  = '0;
    if (w_start) begin
      w_beat_valid = 1'b1;
      w_beat_first = 1'b1;
      w_beat_bit   = BIT_MSB;
      w_beat_act   = w_start_act;
      w_beat_w     = r_w_shadow;
    end else if (r_state == S_SHIFT && r_bit != '0) begin
      w_beat_valid = 1'b1;
      w_beat_bit   = r_bit - BW'(1);
    end
    w_beat_last = w_beat_valid && (w_beat_bit == '0);
    for (int k = 0; k < LANES; k++)
      w_lane_next[k] = (w_beat_valid && w_beat_act[k][w_beat_bit]) ? w_beat_w[k] : '0;
  end

  // NOTE: the weight banks are flop arrays rather than RAM, so reset can and does clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit        <= '0;
      r_gap_cnt    <= '0;
      r_w_shadow   <= '0;
      r_w_active   <= '0;
      r_act        <= '0;
      r_pend_act   <= '0;
      r_pend_valid <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_bit_idx    <= '0;
      r_lane_out   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit     <= w_bit_next;
      r_gap_cnt <= w_gap_cnt_next;
      if (w_load) r_w_shadow[w_addr] <= w_data;
      if (w_start) begin
        r_w_active <= r_w_shadow;
        r_act      <= w_start_act;
      end
      if (w_start && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end else if (w_accept && !w_free) begin
        r_pend_valid <= 1'b1;
        r_pend_act   <= w_act_in;
      end
      r_out_valid <= w_beat_valid;
      r_out_first <= w_beat_first;
      r_out_last  <= w_beat_last;
      r_bit_idx   <= w_beat_bit;
      r_lane_out  <= w_lane_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign bit_idx   = r_bit_idx;
  assign lane_out  = r_lane_out;
endmodule

// File: tb/tb_bitserial_lane_feeder.sv
// Bench for bitserial_lane_feeder: GAP_CYCLES=0 and GAP_CYCLES=1 instances checked every
// cycle against a schedule model (start edge = max(accept edge, previous start + 4 + gap)).
module tb_bitserial_lane_feeder;
  localparam int LANES = 32;
  localparam int WW    = 4;
  localparam int AW    = 4;

  typedef logic [LANES-1:0][WW-1:0] bank_t;
  typedef logic [LANES-1:0][AW-1:0] vec_t;
  typedef struct {
    bit    v;
    int    s;
    vec_t  act;
    bank_t w;
  } slot_t;

  logic       clk, rst, w_load;
  logic [4:0] w_addr;
  logic [3:0] w_data;
  logic       iv  [2];
  vec_t       av  [2];
  logic       rdy [2];
  logic       ov  [2];
  logic       of  [2];
  logic       ol  [2];
  logic [1:0] bi  [2];
  bank_t      lo  [2];

  // Instance index equals its GAP_CYCLES value.
  bitserial_lane_feeder #(.LANES(LANES), .WW(WW), .AW(AW), .GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_addr(w_addr), .w_data(w_data),
    .in_valid(iv[0]), .in_ready(rdy[0]), .act_in(av[0]), .out_valid(ov[0]),
    .out_first(of[0]), .out_last(ol[0]), .bit_idx(bi[0]), .lane_out(lo[0]));

  bitserial_lane_feeder #(.LANES(LANES), .WW(WW), .AW(AW), .GAP_CYCLES(1)) u_dut_g1 (
    .clk(clk), .rst(rst), .w_load(w_load), .w_addr(w_addr), .w_data(w_data),
    .in_valid(iv[1]), .in_ready(rdy[1]), .act_in(av[1]), .out_valid(ov[1]),
    .out_first(of[1]), .out_last(ol[1]), .bit_idx(bi[1]), .lane_out(lo[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_checks = 0;
  int    n_pass   = 0;
  int    edge_n   = 0;
  bank_t shadow;
  slot_t cur  [2];
  slot_t pend [2];
  int    next_free [2];
  bit    accepted  [2];
  bit    e_valid [2];
  bit    e_first [2];
  bit    e_last  [2];
  bit    e_ready [2];
  logic [1:0] e_bit [2];
  bank_t e_lane [2];
  int    e_dot  [2];
  int    acc    [2];
  int    run    [2];
  int    max_run   [2];
  int    last_end  [2];
  int    first_gap [2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int dot(input vec_t a, input bank_t w);
    int s = 0;
    for (int k = 0; k < LANES; k++) s += int'(a[k]) * int'(w[k]);
    return s;
  endfunction

  function automatic int lane_sum(input bank_t l);
    int s = 0;
    for (int k = 0; k < LANES; k++) s += int'(l[k]);
    return s;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  function automatic vec_t fill_vec(input logic [3:0] x);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = x;
    return v;
  endfunction

  // Called at each rising edge, before the shadow bank takes this edge's write.
  task automatic model_edge(input int d);
    int s;
    int k;
    accepted[d] = 1'b0;
    if (rst === 1'b1) begin
      cur[d].v     = 1'b0;
      pend[d].v    = 1'b0;
      next_free[d] = 0;
    end else if (iv[d] === 1'b1 && !pend[d].v) begin
      accepted[d]  = 1'b1;
      s            = (edge_n > next_free[d]) ? edge_n : next_free[d];
      next_free[d] = s + AW + d;
      if (s == edge_n) begin
        cur[d].v   = 1'b1;
        cur[d].s   = edge_n;
        cur[d].act = av[d];
        cur[d].w   = shadow;
      end else begin
        pend[d].v   = 1'b1;
        pend[d].s   = s;
        pend[d].act = av[d];
      end
    end else if (pend[d].v && pend[d].s == edge_n) begin
      cur[d].v   = 1'b1;
      cur[d].s   = edge_n;
      cur[d].act = pend[d].act;
      cur[d].w   = shadow;
      pend[d].v  = 1'b0;
    end
    e_valid[d] = 1'b0;
    e_first[d] = 1'b0;
    e_last[d]  = 1'b0;
    e_bit[d]   = 2'd0;
    e_lane[d]  = '0;
    e_ready[d] = !pend[d].v;
    k = edge_n - cur[d].s;
    if (cur[d].v && k >= 0 && k < AW) begin
      e_valid[d] = 1'b1;
      e_first[d] = (k == 0);
      e_last[d]  = (k == AW - 1);
      e_bit[d]   = 2'(AW - 1 - k);
      e_dot[d]   = dot(cur[d].act, cur[d].w);
      for (int j = 0; j < LANES; j++)
        e_lane[d][j] = cur[d].act[j][AW-1-k] ? cur[d].w[j] : 4'd0;
    end
  endtask

  task automatic observe(input int d);
    check($sformatf("g%0d out_valid", d), ov[d], e_valid[d]);
    check($sformatf("g%0d out_first", d), of[d], e_first[d]);
    check($sformatf("g%0d out_last", d), ol[d], e_last[d]);
    check($sformatf("g%0d bit_idx", d), bi[d], e_bit[d]);
    check($sformatf("g%0d lane_out", d), lo[d], e_lane[d]);
    check($sformatf("g%0d in_ready", d), rdy[d], e_ready[d]);
    if (ov[d] === 1'b1) begin
      if (of[d] === 1'b1) acc[d] = 0;
      acc[d] += lane_sum(lo[d]) << bi[d];
      run[d]++;
    end else begin
      run[d] = 0;
    end
    if (run[d] > max_run[d]) max_run[d] = run[d];
    if (of[d] === 1'b1) first_gap[d] = edge_n - last_end[d];
    if (ol[d] === 1'b1) last_end[d] = edge_n;
    if (e_last[d]) check($sformatf("g%0d shift_add_sum", d), acc[d], e_dot[d]);
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    for (int d = 0; d < 2; d++) model_edge(d);
    if (rst === 1'b1)        shadow = '0;
    else if (w_load === 1'b1) shadow[w_addr] = w_data;
    #1;
    for (int d = 0; d < 2; d++) observe(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_w(input int addr, input int data);
    w_load = 1'b1;
    w_addr = 5'(addr);
    w_data = 4'(data);
    tick();
    w_load = 1'b0;
  endtask

  task automatic send_both(input vec_t a);
    iv[0] = 1'b1;
    iv[1] = 1'b1;
    av[0] = a;
    av[1] = a;
    tick();
    iv[0] = 1'b0;
    iv[1] = 1'b0;
  endtask

  // in_valid held high for three vectors on one instance; the other stays idle.
  task automatic stream(input int d);
    int n_acc = 0;
    max_run[d] = 0;
    iv[d] = 1'b1;
    av[d] = rand_vec();
    for (int budget = 0; budget < 40 && n_acc < 3; budget++) begin
      tick();
      if (accepted[d]) begin
        n_acc++;
        av[d] = rand_vec();
      end
    end
    iv[d] = 1'b0;
    check($sformatf("g%0d stream accepts", d), n_acc, 3);
    idle(14);
    check($sformatf("g%0d burst spacing", d), first_gap[d], d + 1);
    check($sformatf("g%0d longest valid run", d), max_run[d], (d == 0) ? 12 : 4);
  endtask

  initial begin
    vec_t a;
    rst    = 1'b0;
    w_load = 1'b0;
    w_addr = '0;
    w_data = '0;
    shadow = '0;
    for (int d = 0; d < 2; d++) begin
      iv[d]        = 1'b0;
      av[d]        = '0;
      cur[d].v     = 1'b0;
      cur[d].s     = 0;
      pend[d].v    = 1'b0;
      pend[d].s    = 0;
      next_free[d] = 0;
      acc[d]       = 0;
      run[d]       = 0;
      max_run[d]   = 0;
      last_end[d]  = -100;
      first_gap[d] = 0;
    end
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // Full scale: every lane 15 on all beats, sum 7200.
    for (int k = 0; k < LANES; k++) write_w(k, 15);
    send_both(fill_vec(4'hF));
    idle(6);

    // Zero activations: four valid beats of zeros.
    send_both(fill_vec(4'h0));
    idle(6);

    // Bit pattern 1010 against w[k] = k mod 16.
    for (int k = 0; k < LANES; k++) write_w(k, k % 16);
    send_both(fill_vec(4'b1010));
    idle(6);

    // Weight isolation: rewrite lane 0 during beat 2 of the vector in flight.
    write_w(0, 3);
    a    = rand_vec();
    a[0] = 4'hF;
    send_both(a);
    tick();
    write_w(0, 7);
    idle(4);
    send_both(a);
    idle(6);

    // Streaming three vectors, gap 1 then back-to-back.
    stream(1);
    stream(0);

    // Random traffic with concurrent weight writes.
    for (int c = 0; c < 200; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = ($urandom_range(0, 2) != 0);
        av[d] = rand_vec();
      end
      w_load = ($urandom_range(0, 3) == 0);
      w_addr = 5'($urandom_range(0, 31));
      w_data = 4'($urandom_range(0, 15));
      tick();
    end
    iv[0]  = 1'b0;
    iv[1]  = 1'b0;
    w_load = 1'b0;
    idle(12);

    // Reset mid-burst on beat 2 with a vector pending.
    for (int k = 0; k < LANES; k++) write_w(k, (k % 15) + 1);
    send_both(fill_vec(4'hF));
    iv[0] = 1'b1;
    iv[1] = 1'b1;
    av[0] = rand_vec();
    av[1] = av[0];
    tick();
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("g%0d async rst out_valid", d), ov[d], 1'b0);
      check($sformatf("g%0d async rst lane_out", d), lo[d], '0);
      check($sformatf("g%0d async rst in_ready", d), rdy[d], 1'b1);
    end
    idle(2);
    rst = 1'b0;
    idle(8);
    send_both(fill_vec(4'hF));
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
